// File: rtl/button_debounce_repeat.sv
// Push-button conditioner: per channel a 2-FF synchroniser, a counter debouncer and a
// hold-to-repeat FSM producing one-clock press events for a PIO edge-capture input.
module button_debounce_repeat #(
   parameter int               WIDTH           = 4,
   parameter bit               ACTIVE_LOW      = 1'b1,
   parameter int               DEBOUNCE_CYCLES = 1_000_000,
   parameter int               REPEAT_DELAY    = 15_000_000,
   parameter int               REPEAT_RATE     = 5_000_000,
   parameter logic [WIDTH-1:0] REPEAT_MASK     = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] btn_raw,
   input  logic             repeat_en,
   output logic [WIDTH-1:0] btn_state,
   output logic [WIDTH-1:0] btn_event
);

   localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DELAY,
      S_REPEAT,
      S_HOLD
   } rpt_state_e;

   // Normalising before the flops makes the reset value 0 mean "released" in both polarities.
   logic [WIDTH-1:0] btn_norm;
   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;

   assign btn_norm = ACTIVE_LOW ? ~btn_raw : btn_raw;

   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_norm;
         sync2_q <= sync1_q;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      logic             state_q, state_d;
      logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
      rpt_state_e       fsm_q, fsm_d;
      logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
      logic             event_q, event_d;
      logic             rpt_ok;

      assign rpt_ok = REPEAT_MASK[i] & repeat_en;

      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      always_comb begin
         state_d  = state_q;
         db_cnt_d = db_cnt_q;
         if (sync2_q[i] == state_q) begin
            db_cnt_d = '0;
         end else if (db_cnt_q == DB_LAST) begin
            state_d  = sync2_q[i];
            db_cnt_d = '0;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            state_q   <= 1'b0;
            db_cnt_q  <= '0;
            fsm_q     <= S_IDLE;
            rpt_cnt_q <= '0;
            event_q   <= 1'b0;
         end else begin
            state_q   <= state_d;
            db_cnt_q  <= db_cnt_d;
            fsm_q     <= fsm_d;
            rpt_cnt_q <= rpt_cnt_d;
            event_q   <= event_d;
         end
      end

      // Release is checked first everywhere, so it wins over a coincident terminal count.
      always_comb begin
         fsm_d = fsm_q;
         unique case (fsm_q)
            S_IDLE:   if (state_q) fsm_d = rpt_ok ? S_DELAY : S_HOLD;
            S_DELAY: begin
               if (!state_q)                  fsm_d = S_IDLE;
               else if (!rpt_ok)              fsm_d = S_HOLD;
               else if (rpt_cnt_q == DELAY_LAST) fsm_d = S_REPEAT;
            end
            S_REPEAT: begin
               if (!state_q)     fsm_d = S_IDLE;
               else if (!rpt_ok) fsm_d = S_HOLD;
            end
            S_HOLD:   if (!state_q) fsm_d = S_IDLE;
            default:  fsm_d = S_IDLE;
         endcase
      end

      always_comb begin
         event_d   = 1'b0;
         rpt_cnt_d = rpt_cnt_q;
         unique case (fsm_q)
            S_IDLE: begin
               if (state_q) begin
                  event_d   = 1'b1;
                  rpt_cnt_d = '0;
               end
            end
            S_DELAY: begin
               if (state_q && rpt_ok) begin
                  if (rpt_cnt_q == DELAY_LAST) begin
                     event_d   = 1'b1;
                     rpt_cnt_d = '0;
                  end else begin
                     rpt_cnt_d = rpt_cnt_q + 1'b1;
                  end
               end
            end
            S_REPEAT: begin
               if (state_q && rpt_ok) begin
                  if (rpt_cnt_q == RATE_LAST) begin
                     event_d   = 1'b1;
                     rpt_cnt_d = '0;
                  end else begin
                     rpt_cnt_d = rpt_cnt_q + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end

      assign btn_state[i] = state_q;
      assign btn_event[i] = event_q;
   end

endmodule

// File: tb/tb_button_debounce_repeat.sv
// Directed bench for button_debounce_repeat: per-cycle expected tables of raw drive,
// debounced level and event pulses, written out by hand for each scenario.
module tb_button_debounce_repeat;

   localparam int N = 64;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] btn_raw = 4'hF;
   logic       repeat_en = 1'b1;
   logic [3:0] btn_state;
   logic [3:0] btn_event;

   int n_cmp = 0;
   int n_bad = 0;

   logic [3:0] raw_tab [N];
   logic [3:0] st_tab  [N];
   logic [3:0] ev_tab  [N];
   logic       ren_tab [N];

   button_debounce_repeat #(
      .WIDTH          (4),
      .ACTIVE_LOW     (1'b1),
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (10),
      .REPEAT_RATE    (3),
      .REPEAT_MASK    (4'b1111)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .btn_raw  (btn_raw),
      .repeat_en(repeat_en),
      .btn_state(btn_state),
      .btn_event(btn_event)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b", tag, got, exp);
      end
   endtask

   task automatic clear_tabs();
      for (int c = 0; c < N; c++) begin
         raw_tab[c] = 4'hF;
         st_tab[c]  = 4'h0;
         ev_tab[c]  = 4'h0;
         ren_tab[c] = 1'b1;
      end
   endtask

   task automatic press(input int ch, input int from, input int to);
      for (int c = from; c <= to; c++) raw_tab[c][ch] = 1'b0;
   endtask

   task automatic held(input int ch, input int from, input int to);
      for (int c = from; c <= to; c++) st_tab[c][ch] = 1'b1;
   endtask

   task automatic pulse(input int ch, input int c);
      ev_tab[c][ch] = 1'b1;
   endtask

   task automatic no_repeat(input int from, input int to);
      for (int c = from; c <= to; c++) ren_tab[c] = 1'b0;
   endtask

   // Cycle c = time after active edge c; values driven in cycle c are seen at edge c+1.
   task automatic run(input string name, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         check($sformatf("%s event c%0d", name, c), btn_event, ev_tab[c]);
         check($sformatf("%s state c%0d", name, c), btn_state, st_tab[c]);
         btn_raw   = raw_tab[c];
         repeat_en = ren_tab[c];
      end
   endtask

   task automatic do_reset(input string name);
      btn_raw   = 4'hF;
      repeat_en = 1'b1;
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check({name, " reset state"}, btn_state, 4'h0);
      check({name, " reset event"}, btn_event, 4'h0);
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
   endtask

   initial begin
      // 1: single press, debounced at 6, initial event at 7, no repeat before 17
      clear_tabs();
      press(0, 0, N - 1);
      held(0, 6, 16);
      pulse(0, 7);
      do_reset("s1");
      run("s1", 17);

      // 2: 3-cycle glitches never reach the debounce count
      clear_tabs();
      for (int k = 0; k < 5; k++) press(1, 6 * k, 6 * k + 2);
      do_reset("s2");
      run("s2", 36);

      // 3: held press with auto-repeat; release falls at 34 so the 35 terminal count loses
      clear_tabs();
      press(2, 0, 27);
      held(2, 6, 33);
      pulse(2, 7);  pulse(2, 17); pulse(2, 20); pulse(2, 23);
      pulse(2, 26); pulse(2, 29); pulse(2, 32);
      do_reset("s3");
      run("s3", 45);

      // 3b: repeat_en dropped during the initial delay leaves only the first event
      clear_tabs();
      press(2, 0, 27);
      held(2, 6, 33);
      pulse(2, 7);
      no_repeat(12, N - 1);
      do_reset("s3b");
      run("s3b", 45);

      // 4: repeat disabled globally, one event per press
      clear_tabs();
      press(3, 0, 29);
      held(3, 6, 35);
      pulse(3, 7);
      no_repeat(0, N - 1);
      do_reset("s4");
      run("s4", 45);

      // 5: simultaneous presses on ch0 and ch2, released at 18, state falls at 24
      clear_tabs();
      press(0, 0, 17);
      press(2, 0, 17);
      held(0, 6, 23);
      held(2, 6, 23);
      for (int k = 0; k < 4; k++) begin
         pulse(0, (k == 0) ? 7 : 14 + 3 * k);
         pulse(2, (k == 0) ? 7 : 14 + 3 * k);
      end
      do_reset("s5");
      run("s5", 35);

      // 6: reset asserted at cycle 15 while held, then a fresh press from reset release
      clear_tabs();
      press(0, 0, N - 1);
      held(0, 6, 14);
      pulse(0, 7);
      do_reset("s6");
      run("s6a", 15);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("s6 mid-reset state", btn_state, 4'h0);
      check("s6 mid-reset event", btn_event, 4'h0);
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      clear_tabs();
      press(0, 0, N - 1);
      held(0, 6, 11);
      pulse(0, 7);
      run("s6b", 12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
